// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants for the ALU command sequencer
package alu_seq_pkg;

    // ALU opcode width; the opcode is carried through the sequencer untouched.
    localparam int SEL_W = 3;

    // Default operand width and command FIFO depth.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Sequencer FSM encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with occupancy count
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   push_i, push_data_i  write request and data (ignored while full)
//   pop_i, pop_data_o    read request (ignored while empty) and head entry
//   count_o              number of stored entries, 0..DEPTH
//   full_o, empty_o      occupancy flags derived from count_o
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 2 * DEF_WIDTH + SEL_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Guard both sides so an over-eager requester cannot corrupt state.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign pop_data_o = mem_q[rd_ptr_q];

    // Storage carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO, ALU issue and result capture stage
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_a, cmd_b, cmd_sel           command operands and opaque opcode
//   alu_a, alu_b, alu_sel           registered operands to the external ALU
//   alu_out                         combinational ALU result (WIDTH+1 bits)
//   rsp_valid/rsp_ready             response handshake
//   rsp_data, rsp_sel               captured result and its opcode
//   count                           command FIFO occupancy
//   busy                            FSM not idle or commands pending
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SEL_W-1:0] cmd_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH:0]   alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_data,
    output logic [SEL_W-1:0] rsp_sel,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    localparam int DATA_W = 2 * WIDTH + SEL_W;

    logic [1:0]        state_q,     state_d;
    logic [WIDTH-1:0]  alu_a_q,     alu_a_d;
    logic [WIDTH-1:0]  alu_b_q,     alu_b_d;
    logic [SEL_W-1:0]  alu_sel_q,   alu_sel_d;
    logic [WIDTH:0]    rsp_data_q,  rsp_data_d;
    logic [SEL_W-1:0]  rsp_sel_q,   rsp_sel_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;

    // Ready depends on occupancy alone: a full FIFO never passes a
    // command straight through, even on a pop cycle.
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    alu_cmd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i ({cmd_a, cmd_b, cmd_sel}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .count_o     (count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_data_d  = rsp_data_q;
        rsp_sel_d   = rsp_sel_q;
        rsp_valid_d = rsp_valid_q;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop                        = 1'b1;
                    {alu_a_d, alu_b_d, alu_sel_d}   = fifo_head;
                    state_d                         = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Operands have been stable for a full cycle; alu_out is settled.
                rsp_data_d  = alu_out;
                rsp_sel_d   = alu_sel_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        // Issue the next command on the same edge as the handshake.
                        fifo_pop                      = 1'b1;
                        {alu_a_d, alu_b_d, alu_sel_d} = fifo_head;
                        state_d                       = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_data_q  <= '0;
            rsp_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_data_q  <= rsp_data_d;
            rsp_sel_q   <= rsp_sel_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_sel   = rsp_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = (state_q != ST_IDLE) || (count != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_a = 8'd0;
    logic [7:0] cmd_b = 8'd0;
    logic [2:0] cmd_sel = 3'd0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [8:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [8:0] rsp_data;
    logic [2:0] rsp_sel;
    logic [2:0] count;
    logic       busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    int rsp_seen = 0;
    int cyc = 0;

    logic [11:0] exp_q [$];
    int          hs_cyc [$];
    logic [11:0] mon_exp;
    logic [8:0]  last_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] s);
        case (s)
            3'b000:  return {1'b0, a};
            3'b001:  return {1'b0, a} + {1'b0, b};
            3'b010:  return {1'b0, a} - {1'b0, b};
            3'b011:  return {1'b0, a & b};
            3'b100:  return {1'b0, a | b};
            3'b101:  return {1'b0, a ^ b};
            3'b110:  return {1'b0, ~a};
            default: return {1'b0, b};
        endcase
    endfunction

    // The ALU lives beside the sequencer, as in the real system.
    assign alu_out = alu_model(alu_a, alu_b, alu_sel);

    alu_cmd_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_sel   (rsp_sel),
        .count     (count),
        .busy      (busy)
    );

    // Scoreboard: every response handshake pops the oldest expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            rsp_seen++;
            hs_cyc.push_back(cyc);
            last_data = rsp_data;
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL rsp_unexpected got data=%0d sel=%0d want=none", rsp_data, rsp_sel);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({rsp_data, rsp_sel} !== mon_exp)
                    $display("FAIL rsp_order got data=%0d sel=%0d want data=%0d sel=%0d",
                             rsp_data, rsp_sel, mon_exp[11:3], mon_exp[2:0]);
                else
                    pass_cnt++;
            end
        end
    end

    // Entered and left at posedge+1; holds cmd_valid until accepted.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                        input logic [11:0] exp, output bit ok);
        logic took;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = s;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            took = cmd_ready;
            if (took) exp_q.push_back(exp);
            @(posedge clk);
            #1;
            if (took) ok = 1'b1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_seen >= target) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (count !== 3'd0) $display("FAIL reset_count got=%0d want=0", count); else pass_cnt++;
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
        total_cnt++;
        if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); else pass_cnt++;
        total_cnt++;
        if ({alu_a, alu_b, alu_sel, rsp_data, rsp_sel} !== 31'd0)
            $display("FAIL reset_regs got a=%0d b=%0d sel=%0d data=%0d rsel=%0d want all 0",
                     alu_a, alu_b, alu_sel, rsp_data, rsp_sel);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_add();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_a     = 8'd10;
        cmd_b     = 8'd5;
        cmd_sel   = 3'b001;
        exp_q.push_back({9'd15, 3'b001});
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL add_ready got=%b want=1", cmd_ready); else pass_cnt++;
        @(posedge clk);                     // edge N: accept
        #1;
        cmd_valid = 1'b0;
        total_cnt++;
        if (count !== 3'd1 || busy !== 1'b1)
            $display("FAIL add_after_accept got count=%0d busy=%b want count=1 busy=1", count, busy);
        else pass_cnt++;
        @(posedge clk);                     // edge N+1: issue
        #1;
        total_cnt++;
        if (alu_a !== 8'd10 || alu_b !== 8'd5 || alu_sel !== 3'b001 || count !== 3'd0 || rsp_valid !== 1'b0)
            $display("FAIL add_issue got a=%0d b=%0d sel=%0d count=%0d v=%b want 10 5 1 0 0",
                     alu_a, alu_b, alu_sel, count, rsp_valid);
        else pass_cnt++;
        @(posedge clk);                     // edge N+2: capture
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_data !== 9'd15 || rsp_sel !== 3'b001)
            $display("FAIL add_capture got v=%b data=%0d sel=%0d want v=1 data=15 sel=1",
                     rsp_valid, rsp_data, rsp_sel);
        else pass_cnt++;
        @(posedge clk);                     // edge N+3: handshake
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL add_done got v=%b busy=%b want v=0 busy=0", rsp_valid, busy);
        else pass_cnt++;
    endtask

    task automatic test_carry();
        bit ok;
        int base;
        base      = rsp_seen;
        rsp_ready = 1'b1;
        send(8'd200, 8'd100, 3'b001, {9'd300, 3'b001}, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL carry_accept got=%b want=1", ok); else pass_cnt++;
        wait_rsp(base + 1, ok);
        total_cnt++;
        if (ok !== 1'b1 || last_data[8] !== 1'b1)
            $display("FAIL carry_bit8 got done=%b data=%0d want done=1 bit8=1", ok, last_data);
        else pass_cnt++;
    endtask

    task automatic test_full();
        bit         ok;
        logic       took;
        int         idx;
        int         acc;
        int         base;
        logic [7:0] a, b;
        logic [2:0] s;
        base      = rsp_seen;
        rsp_ready = 1'b0;
        idx       = 0;
        acc       = 0;
        for (int c = 0; c < 14; c++) begin
            a = 8'(idx * 37 + 11);
            b = 8'(idx * 53 + 7);
            s = 3'(idx + 1);
            cmd_valid = (idx < 6);
            cmd_a     = a;
            cmd_b     = b;
            cmd_sel   = s;
            @(negedge clk);
            took = cmd_valid && cmd_ready;
            if (took) exp_q.push_back({alu_model(a, b, s), s});
            @(posedge clk);
            #1;
            if (took) begin
                idx++;
                acc++;
            end
        end
        total_cnt++;
        if (acc != 5) $display("FAIL full_accepted got=%0d want=5", acc); else pass_cnt++;
        total_cnt++;
        if (count !== 3'd4 || cmd_ready !== 1'b0)
            $display("FAIL full_flags got count=%0d ready=%b want count=4 ready=0", count, cmd_ready);
        else pass_cnt++;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_rsp(base + 5, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL full_drain_timeout got=%0d want=%0d", rsp_seen - base, 5); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (count !== 3'd0 || busy !== 1'b0 || exp_q.size() != 0)
            $display("FAIL full_drained got count=%0d busy=%b left=%0d want 0 0 0", count, busy, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit          ok;
        int          base;
        int          bad;
        logic [27:0] snap;
        base      = rsp_seen;
        rsp_ready = 1'b0;
        send(8'h3C, 8'h0F, 3'b010, {alu_model(8'h3C, 8'h0F, 3'b010), 3'b010}, ok);
        send(8'h81, 8'h7F, 3'b001, {alu_model(8'h81, 8'h7F, 3'b001), 3'b001}, ok);
        for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        total_cnt++;
        if (rsp_valid !== 1'b1 || count !== 3'd1)
            $display("FAIL bp_setup got v=%b count=%0d want v=1 count=1", rsp_valid, count);
        else pass_cnt++;
        snap = {rsp_data, rsp_sel, alu_a, alu_b};
        bad  = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if ({rsp_data, rsp_sel, alu_a, alu_b} !== snap || rsp_valid !== 1'b1) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL bp_stable got unstable_cycles=%0d want=0", bad); else pass_cnt++;
        rsp_ready = 1'b1;
        wait_rsp(base + 2, ok);
        repeat (4) @(posedge clk);
        #1;
        total_cnt++;
        if (rsp_seen - base != 2)
            $display("FAIL bp_handshakes got=%0d want=2", rsp_seen - base);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok3, ok;
        int base;
        base      = rsp_seen;
        rsp_ready = 1'b1;
        hs_cyc.delete();
        send(8'd1, 8'd2, 3'b001, {9'd3, 3'b001}, ok1);
        send(8'd3, 8'd4, 3'b001, {9'd7, 3'b001}, ok2);
        send(8'd5, 8'd6, 3'b001, {9'd11, 3'b001}, ok3);
        total_cnt++;
        if ({ok1, ok2, ok3} !== 3'b111) $display("FAIL b2b_accept got=%b want=111", {ok1, ok2, ok3}); else pass_cnt++;
        wait_rsp(base + 3, ok);
        total_cnt++;
        if (hs_cyc.size() != 3 || hs_cyc[1] - hs_cyc[0] != 2 || hs_cyc[2] - hs_cyc[1] != 2)
            $display("FAIL b2b_spacing got n=%0d gaps=%0d,%0d want n=3 gaps=2,2", hs_cyc.size(),
                     (hs_cyc.size() > 1) ? hs_cyc[1] - hs_cyc[0] : -1,
                     (hs_cyc.size() > 2) ? hs_cyc[2] - hs_cyc[1] : -1);
        else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        bit ok;
        int base;
        int stale;
        rsp_ready = 1'b0;
        send(8'd20, 8'd22, 3'b001, {9'd42, 3'b001}, ok);
        send(8'd77, 8'd3, 3'b011, {alu_model(8'd77, 8'd3, 3'b011), 3'b011}, ok);
        send(8'd90, 8'd9, 3'b101, {alu_model(8'd90, 8'd9, 3'b101), 3'b101}, ok);
        for (int i = 0; i < 20 && !(rsp_valid === 1'b1 && count === 3'd2); i++) begin
            @(posedge clk);
            #1;
        end
        total_cnt++;
        if (rsp_valid !== 1'b1 || count !== 3'd2)
            $display("FAIL rst_setup got v=%b count=%0d want v=1 count=2", rsp_valid, count);
        else pass_cnt++;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0 || count !== 3'd0 || alu_a !== 8'd0 || busy !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL rst_async got v=%b count=%0d a=%0d busy=%b ready=%b want 0 0 0 0 1",
                     rsp_valid, count, alu_a, busy, cmd_ready);
        else pass_cnt++;
        exp_q.delete();
        base = rsp_seen;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        stale     = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0) stale++;
        end
        total_cnt++;
        if (stale != 0 || rsp_seen != base)
            $display("FAIL rst_stale got valid_cycles=%0d rsps=%0d want 0 0", stale, rsp_seen - base);
        else pass_cnt++;
        send(8'd9, 8'd8, 3'b001, {9'd17, 3'b001}, ok);
        wait_rsp(base + 1, ok);
        total_cnt++;
        if (ok !== 1'b1 || last_data !== 9'd17)
            $display("FAIL rst_recover got done=%b data=%0d want done=1 data=17", ok, last_data);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_carry();
        test_full();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL end_scoreboard got left=%0d want=0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got time=%0t want finish earlier", $time);
        $fatal(1);
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Issue/capture stage wrapped around the combinational parameterized ALU (a, b, sel -> WIDTH+1-bit out).
- Upstream: accepts operation commands over a valid/ready handshake and buffers them in a small FIFO.
- ALU side: drives the ALU operands from registers and captures the ALU result into a response register.
- Downstream: presents the result on a valid/ready response port.
- The ALU is instantiated beside this block and is not inside it.

Parameters:
- WIDTH, 8, operand width; the result is WIDTH+1 bits.
- DEPTH, 4, command FIFO entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_a  in  WIDTH  operand a.
- cmd_b  in  WIDTH  operand b.
- cmd_sel  in  3  ALU opcode; passed through opaque.
- alu_a  out  WIDTH  registered operand to the ALU.
- alu_b  out  WIDTH  registered operand to the ALU.
- alu_sel  out  3  registered opcode to the ALU.
- alu_out  in  WIDTH+1  combinational ALU result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  WIDTH+1  captured ALU result.
- rsp_sel  out  3  opcode that produced rsp_data.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.
- busy  out  1  high when state != IDLE or count != 0.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, FIFO empty, count=0, busy=0.
  - alu_a, alu_b, alu_sel, rsp_data, rsp_sel all 0; rsp_valid=0.
  - cmd_ready follows count, so it is 1 while in reset.
  - Reset mid-operation discards queued, in-flight and unconsumed results. No partial output after deassertion.
- FIFO:
  - cmd_ready = (count != DEPTH), combinational from count only; no pass-through when full.
  - Push on cmd_valid && cmd_ready.
  - Pop only when the FSM issues.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - cmd_valid while full is ignored; the FIFO is not corrupted.
- FSM states IDLE, EXEC, RESP:
  - IDLE: if count != 0, pop the head into alu_a/alu_b/alu_sel and go to EXEC.
  - EXEC: alu_out is valid this cycle. Capture alu_out into rsp_data and alu_sel into rsp_sel, set rsp_valid=1, go to RESP.
  - RESP, rsp_ready=0: hold. rsp_data, rsp_sel and the alu_* registers stay stable.
  - RESP, rsp_ready=1, count != 0: clear rsp_valid, pop the next command into the alu_* registers, go to EXEC (same edge).
  - RESP, rsp_ready=1, count == 0: clear rsp_valid, go to IDLE. alu_* keep their last values.
- Latency: command accepted at edge N (empty and idle) -> alu_* updated at edge N+1 -> rsp_valid high after edge N+2.
- Throughput: one result per 2 cycles with rsp_ready held high.
- Ordering: strictly FIFO; results return in command order.
- Width: rsp_data is alu_out verbatim (WIDTH+1 bits). No truncation or extension here.
- Operand registers change only on a pop edge, so the ALU inputs are glitch-free between issues.

Decomposition:
- Package alu_seq_pkg contains:
  - SEL_W = 3.
  - FSM state encodings ST_IDLE, ST_EXEC, ST_RESP.
  - Default WIDTH and DEPTH constants.
- Sub-module alu_cmd_fifo: synchronous FIFO, parameterized on data width (2*WIDTH+SEL_W) and DEPTH, with push/pop/count/full/empty.
- The FSM and the capture registers stay in alu_cmd_sequencer.

Test Plan:
Bench instantiates alu_cmd_sequencer, WIDTH=8, DEPTH=4, connected to the ALU (sel 3'b001 = add).
1. Single add: cmd a=8'd10, b=8'd5, sel=3'b001, rsp_ready=1 -> rsp_valid rises 2 edges after accept, rsp_data=9'd15, rsp_sel=3'b001, then busy=0.
2. Carry: a=8'd200, b=8'd100, sel=3'b001 -> rsp_data=9'd300 (bit 8 = 1).
3. Full: rsp_ready=0, cmd_valid held with 6 distinct commands -> exactly 5 accepted, cmd_ready=0 once count=4, count=4. Then raise rsp_ready -> 5 responses in order, count drains to 0.
4. Backpressure: rsp_ready=0 for 10 cycles while rsp_valid=1 -> rsp_data, rsp_sel, alu_a, alu_b stable every cycle. Raise rsp_ready -> exactly one handshake per result.
5. Streaming: 3 back-to-back commands (1+2, 3+4, 5+6, sel=3'b001), rsp_ready=1 -> rsp_data 9'd3, 9'd7, 9'd11 on consecutive 2-cycle slots.
6. Reset mid-op: rst_n low asynchronously while in RESP with count=2 -> rsp_valid=0, count=0, alu_a=0 immediately (before the next clk edge). After release, no stale response appears and a new command completes normally.
